uart_word_streamer: RTL and testbench
=====================================

Name: uart_word_streamer

Overview:
- Parametrised host-side UART word engine; successor to the bench-level 16-bit wr_en/Tx_busy driving of the uart block.
- Holds a buffer of DATA_W-bit words and serialises them byte-by-byte into a byte-wide UART transmitter using the busy handshake.
- Concurrently reassembles received bytes into words in a second buffer.
- Used to bulk-load image data into processor_top_module and capture its output, in simulation and on board.

Parameters:
- DATA_W, 16, word width; must be a multiple of 8; BPW = DATA_W/8 bytes per word.
- DEPTH, 16, words in each of the TX and RX buffers; power of two; AW = log2(DEPTH).
- MSB_FIRST, 1, 1 = most-significant byte sent/received first, 0 = least-significant first.
- RX_TIMEOUT, 1000000, idle clk cycles after which a partial RX word is discarded.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load_we  in  1  write strobe into the TX buffer.
- load_addr  in  AW  TX buffer write address.
- load_data  in  DATA_W  TX buffer write data.
- start  in  1  one-cycle pulse; begin a transfer.
- word_count  in  AW+1  words to send, 0..DEPTH; sampled on start.
- tx_byte  out  8  byte to the UART transmitter.
- tx_wr_en  out  1  one-cycle write pulse to the transmitter.
- tx_busy  in  1  transmitter busy.
- rx_byte  in  8  received byte.
- rx_ready  in  1  receiver holds a valid byte.
- rx_ready_clr  out  1  one-cycle acknowledge to the receiver.
- rd_addr  in  AW  RX buffer read address.
- rd_data  out  DATA_W  RX buffer read data, registered, 1-cycle latency.
- busy  out  1  TX transfer in progress.
- done  out  1  one-cycle pulse when the TX transfer completes.
- rx_count  out  AW+1  words stored in the RX buffer since the last start.
- rx_overflow  out  1  sticky; a word arrived while the RX buffer was full.
- rx_timeout  out  1  sticky; a partial word was discarded.

Behaviour:
- Reset (async, low): all outputs 0, both FSMs idle, word/byte indices 0. Buffer contents are not cleared.
- load_we writes on the clock edge only when busy=0; it is ignored while busy=1.

TX FSM:
- IDLE:
  - start && word_count==0 → DONE.
  - start otherwise → FETCH; latch word_count, set word index=0, busy=1.
  - start while busy=1 is ignored.
- FETCH: read buffer[word index] into the shift register; set byte index=0 → ISSUE.
- ISSUE:
  - When tx_busy==0: drive tx_byte from the current byte lane and pulse tx_wr_en for exactly 1 cycle → ACK.
  - Stall while tx_busy==1.
  - Byte lane: MSB_FIRST=1 sends bits [DATA_W-1 -: 8] first; MSB_FIRST=0 sends [7:0] first.
- ACK: wait for tx_busy==1 → DRAIN. Never re-pulse tx_wr_en in this state.
- DRAIN: wait for tx_busy==0.
  - Next byte → ISSUE.
  - Last byte of the word, more words remaining → FETCH.
  - Last byte of the last word → DONE.
- DONE: done=1 for 1 cycle, busy=0 → IDLE.
- tx_byte holds its value from the wr_en pulse until the next pulse.

RX path (independent of the TX FSM, runs always):
- When rx_ready==1 and the armed flag is set:
  - Capture rx_byte.
  - Pulse rx_ready_clr for 1 cycle.
  - Clear armed.
  - Re-arm when rx_ready is seen at 0. Each byte is captured exactly once.
- Bytes shift into the assembly register per MSB_FIRST.
- After BPW bytes the word is written to RX buffer[rx_count].
  - If rx_count<DEPTH: rx_count increments.
  - If rx_count==DEPTH: the word is dropped, rx_count saturates, rx_overflow set.
- Idle counter resets on every captured byte.
  - With 1..BPW-1 bytes held and the counter reaching RX_TIMEOUT: discard the partial word and set rx_timeout.
  - The counter does not run when no bytes are held.
- start clears rx_count, rx_overflow, rx_timeout and any partial word.
  - If a byte completes a word in the same cycle as start, the start clear wins; that word is not stored.
- rd_data = RX buffer[rd_addr], registered. Reading the entry being written in the same cycle returns the old data.

Test Plan:
- Load 0xA1B2, 0xC3D4, MSB_FIRST=1; start with word_count=2; UART model busy 10 cycles per byte → tx_byte sequence A1,B2,C3,D4; four 1-cycle tx_wr_en pulses; done once; busy low after.
- MSB_FIRST=0, word 0x1234 → bytes 34,12. start with word_count=0 → done 2 cycles later, no tx_wr_en.
- Hold tx_busy=1 for 50 cycles before start → no tx_wr_en until tx_busy falls. Pulse start again mid-transfer → ignored, byte count unchanged.
- Feed RX bytes 5A,A5,0F,F0 with rx_ready held until rx_ready_clr → rx_count=2; rd_addr 0/1 return 0x5AA5/0x0FF0 one cycle later. Exactly 4 rx_ready_clr pulses.
- Send one RX byte, then idle RX_TIMEOUT (set 20) cycles → rx_timeout=1, rx_count unchanged; next two bytes form a clean word.
- Fill DEPTH+1 RX words → rx_count=DEPTH, rx_overflow=1. Assert reset mid-TX → tx_wr_en, busy, done immediately 0; restart with the same load sends correctly.

Source files
------------

// File: rtl/uart_word_streamer.sv
// uart_word_streamer: serialises a buffer of DATA_W-bit words into a byte-wide
// UART transmitter using its busy handshake, and reassembles received bytes
// into words in a second buffer.
module uart_word_streamer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned RX_TIMEOUT = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_we,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [DATA_W-1:0]          load_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     word_count,
    output logic [7:0]                 tx_byte,
    output logic                       tx_wr_en,
    input  logic                       tx_busy,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_ready,
    output logic                       rx_ready_clr,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     rx_count,
    output logic                       rx_overflow,
    output logic                       rx_timeout
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BPW = DATA_W / 8;
    localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned TW  = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_ACK,
        S_DRAIN,
        S_DONE
    } tx_state_t;

    logic [DATA_W-1:0] tx_mem [DEPTH];
    logic [DATA_W-1:0] rx_mem [DEPTH];

    tx_state_t         state;
    logic [DATA_W-1:0] tx_shift;
    logic [CW-1:0]     word_idx;
    logic [CW-1:0]     word_total;
    logic [BIW-1:0]    tx_bidx;

    logic [7:0]        tx_lane_c;
    logic [DATA_W-1:0] tx_shift_next_c;

    logic              armed;
    logic [DATA_W-1:0] rx_shift;
    logic [BIW-1:0]    rx_bidx;
    logic [TW-1:0]     idle_cnt;

    logic              capture_c;
    logic              word_done_c;
    logic              rx_we_c;
    logic [DATA_W-1:0] rx_shift_next_c;

    // TX buffer write port; locked out while a transfer is running
    always_ff @(posedge clk) begin
        if (load_we && !busy) begin
            tx_mem[load_addr] <= load_data;
        end
    end

    // Current outgoing byte lane and the shift register after it is consumed
    always_comb begin
        tx_lane_c       = 8'h00;
        tx_shift_next_c = tx_shift;
        if (MSB_FIRST != 0) begin
            tx_lane_c       = tx_shift[DATA_W-1 -: 8];
            tx_shift_next_c = tx_shift << 8;
        end else begin
            tx_lane_c       = tx_shift[7:0];
            tx_shift_next_c = tx_shift >> 8;
        end
    end

    // TX sequencer: fetch word, issue each byte on tx_busy low, wait for the
    // transmitter to take it (busy high) and finish it (busy low)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            tx_wr_en   <= 1'b0;
            tx_byte    <= 8'h00;
            tx_shift   <= '0;
            word_idx   <= '0;
            word_total <= '0;
            tx_bidx    <= '0;
        end else begin
            tx_wr_en <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state <= S_DONE;
                        end else begin
                            word_total <= word_count;
                            word_idx   <= '0;
                            busy       <= 1'b1;
                            state      <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    tx_shift <= tx_mem[word_idx[AW-1:0]];
                    tx_bidx  <= '0;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!tx_busy) begin
                        tx_byte  <= tx_lane_c;
                        tx_wr_en <= 1'b1;
                        tx_shift <= tx_shift_next_c;
                        state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (tx_busy) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_busy) begin
                        if (tx_bidx == BIW'(BPW - 1)) begin
                            if (word_idx == word_total - CW'(1)) begin
                                state <= S_DONE;
                            end else begin
                                word_idx <= word_idx + CW'(1);
                                state    <= S_FETCH;
                            end
                        end else begin
                            tx_bidx <= tx_bidx + BIW'(1);
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // RX byte capture, assembly and buffer write decision
    always_comb begin
        capture_c       = rx_ready && armed;
        word_done_c     = capture_c && (rx_bidx == BIW'(BPW - 1));
        rx_we_c         = word_done_c && !start && (rx_count < CW'(DEPTH));
        rx_shift_next_c = rx_shift;
        if (MSB_FIRST != 0) begin
            rx_shift_next_c = (rx_shift << 8) | DATA_W'(rx_byte);
        end else begin
            rx_shift_next_c = (rx_shift >> 8) | (DATA_W'(rx_byte) << (DATA_W - 8));
        end
    end

    // RX buffer write port
    always_ff @(posedge clk) begin
        if (rx_we_c) begin
            rx_mem[rx_count[AW-1:0]] <= rx_shift_next_c;
        end
    end

    // RX handshake, word assembly, counters and sticky flags; start wins over
    // any byte landing in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed        <= 1'b1;
            rx_ready_clr <= 1'b0;
            rx_shift     <= '0;
            rx_bidx      <= '0;
            idle_cnt     <= '0;
            rx_count     <= '0;
            rx_overflow  <= 1'b0;
            rx_timeout   <= 1'b0;
        end else begin
            rx_ready_clr <= 1'b0;
            if (capture_c) begin
                rx_ready_clr <= 1'b1;
                armed        <= 1'b0;
            end else if (!rx_ready) begin
                armed <= 1'b1;
            end

            if (start) begin
                rx_count    <= '0;
                rx_overflow <= 1'b0;
                rx_timeout  <= 1'b0;
                rx_shift    <= '0;
                rx_bidx     <= '0;
                idle_cnt    <= '0;
            end else if (capture_c) begin
                idle_cnt <= '0;
                if (word_done_c) begin
                    rx_shift <= '0;
                    rx_bidx  <= '0;
                    if (rx_count < CW'(DEPTH)) begin
                        rx_count <= rx_count + CW'(1);
                    end else begin
                        rx_overflow <= 1'b1;
                    end
                end else begin
                    rx_shift <= rx_shift_next_c;
                    rx_bidx  <= rx_bidx + BIW'(1);
                end
            end else if (rx_bidx != '0) begin
                if (idle_cnt == TW'(RX_TIMEOUT - 1)) begin
                    rx_shift   <= '0;
                    rx_bidx    <= '0;
                    idle_cnt   <= '0;
                    rx_timeout <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end

    // Registered RX buffer read; same-cycle write returns the old entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rx_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_uart_word_streamer.sv
// Self-checking bench for uart_word_streamer: table vectors, corner-case
// sequences and randomized transfers against a byte/word reference model.
module tb_uart_word_streamer;

    localparam int unsigned DW  = 16;
    localparam int unsigned DEP = 16;
    localparam int unsigned TO  = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    // MSB-first instance
    logic        load_we = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic        start = 1'b0;
    logic [4:0]  word_count = '0;
    logic [7:0]  tx_byte;
    logic        tx_wr_en;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rx_ready = 1'b0;
    logic        rx_ready_clr;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [4:0]  rx_count;
    logic        rx_overflow;
    logic        rx_timeout;

    // LSB-first instance
    logic        l_load_we = 1'b0;
    logic [3:0]  l_load_addr = '0;
    logic [15:0] l_load_data = '0;
    logic        l_start = 1'b0;
    logic [4:0]  l_word_count = '0;
    logic [7:0]  l_tx_byte;
    logic        l_tx_wr_en;
    logic        l_tx_busy = 1'b0;
    logic        l_rx_ready_clr;
    logic [15:0] l_rd_data;
    logic        l_busy;
    logic        l_done;
    logic [4:0]  l_rx_count;
    logic        l_rx_overflow;
    logic        l_rx_timeout;

    uart_word_streamer #(.DATA_W(DW), .DEPTH(DEP), .MSB_FIRST(1), .RX_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .word_count(word_count),
        .tx_byte(tx_byte), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
        .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_ready_clr(rx_ready_clr),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .rx_count(rx_count), .rx_overflow(rx_overflow), .rx_timeout(rx_timeout)
    );

    uart_word_streamer #(.DATA_W(DW), .DEPTH(DEP), .MSB_FIRST(0), .RX_TIMEOUT(TO)) dut_l (
        .clk(clk), .reset(reset), .load_we(l_load_we), .load_addr(l_load_addr),
        .load_data(l_load_data), .start(l_start), .word_count(l_word_count),
        .tx_byte(l_tx_byte), .tx_wr_en(l_tx_wr_en), .tx_busy(l_tx_busy),
        .rx_byte(8'h00), .rx_ready(1'b0), .rx_ready_clr(l_rx_ready_clr),
        .rd_addr(4'h0), .rd_data(l_rd_data), .busy(l_busy), .done(l_done),
        .rx_count(l_rx_count), .rx_overflow(l_rx_overflow), .rx_timeout(l_rx_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // UART transmitter model state
    int         lat = 10;
    int         busy_cnt = 0;
    bit         hold_busy = 1'b0;
    logic [7:0] got_q [$];
    int         wr_pulses = 0;
    int         wide_pulses = 0;
    int         done_cnt = 0;
    int         clr_cnt = 0;
    logic       prev_wr = 1'b0;
    logic [7:0] l_got [$];
    int         l_cnt = 0;
    int         l_done_cnt = 0;

    logic [15:0] tx_words [16];
    logic [7:0]  exp_q [$];

    typedef struct packed {
        logic [31:0]     n;
        logic [31:0]     l;
        logic [0:3][15:0] w;
        logic [0:7][7:0]  exp;
    } tx_vec_t;

    typedef struct packed {
        logic [31:0]     nb;
        logic [0:3][7:0] b;
        logic [31:0]     exp_count;
        logic [15:0]     w0;
        logic [15:0]     w1;
    } rx_vec_t;

    // Transmitter responders: record bytes, raise busy for lat cycles per byte
    always @(negedge clk) begin
        if (tx_wr_en) begin
            got_q.push_back(tx_byte);
            wr_pulses++;
            busy_cnt = lat;
            if (prev_wr) wide_pulses++;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        prev_wr = tx_wr_en;
        tx_busy = hold_busy || (busy_cnt > 0);
        if (done) done_cnt++;
        if (rx_ready_clr) clr_cnt++;
    end

    always @(negedge clk) begin
        if (l_tx_wr_en) begin
            l_got.push_back(l_tx_byte);
            l_cnt = 3;
        end else if (l_cnt > 0) begin
            l_cnt--;
        end
        l_tx_busy = (l_cnt > 0);
        if (l_done) l_done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_word(input int addr, input logic [15:0] data);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = 4'(addr);
        load_data = data;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic pulse_start(input int wc);
        @(negedge clk);
        start      = 1'b1;
        word_count = 5'(wc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound);
        int k;
        k = 0;
        while (done_cnt <= d0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    // Run one transfer of n words with lat busy cycles per byte
    task automatic run_tx(input int n, input int l, input bit do_load);
        int d0, w0, x0;
        lat = l;
        if (do_load) for (int i = 0; i < n; i++) load_word(i, tx_words[i]);
        got_q.delete();
        d0 = done_cnt; w0 = wr_pulses; x0 = wide_pulses;
        pulse_start(n);
        wait_done(d0, 20000);
        check("wr_pulse_count", 32'(wr_pulses - w0), 32'(2 * n));
        check("wr_pulse_width", 32'(wide_pulses - x0), 32'd0);
    endtask

    // Reference: bytes of each word, most-significant first
    task automatic build_exp(input int n);
        exp_q.delete();
        for (int w = 0; w < n; w++)
            for (int b = 0; b < 2; b++)
                exp_q.push_back(8'((32'(tx_words[w]) >> (8 * (1 - b))) & 32'hFF));
    endtask

    task automatic compare_got(input string name);
        logic [7:0] g;
        check({name, "_size"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = 8'hxx;
            if (i < got_q.size()) g = got_q[i];
            check(name, 32'(g), 32'(exp_q[i]));
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        int k;
        @(negedge clk);
        rx_byte  = b;
        rx_ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rx_ready_clr && k < 50);
        rx_ready = 1'b0;
        if (k >= 50) check("rx_clr_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic read_rx(input string name, input int addr, input logic [15:0] exp);
        @(negedge clk);
        rd_addr = 4'(addr);
        @(negedge clk);
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic clear_rx();
        pulse_start(0);
        repeat (3) @(negedge clk);
    endtask

    tx_vec_t tx_tbl [4];
    rx_vec_t rx_tbl [3];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, nw, stored, k;
        logic [7:0]  b0, b1;
        logic [15:0] exp_words [$];

        tx_tbl[0] = '{n: 2, l: 10, w: 64'hA1B2_C3D4_0000_0000, exp: 64'hA1B2_C3D4_0000_0000};
        tx_tbl[1] = '{n: 1, l: 1,  w: 64'hFF00_0000_0000_0000, exp: 64'hFF00_0000_0000_0000};
        tx_tbl[2] = '{n: 3, l: 3,  w: 64'h0001_8000_7E81_0000, exp: 64'h0001_8000_7E81_0000};
        tx_tbl[3] = '{n: 4, l: 2,  w: 64'h1111_2222_3333_4444, exp: 64'h1111_2222_3333_4444};
        rx_tbl[0] = '{nb: 4, b: 32'h5AA5_0FF0, exp_count: 2, w0: 16'h5AA5, w1: 16'h0FF0};
        rx_tbl[1] = '{nb: 4, b: 32'hFF00_0180, exp_count: 2, w0: 16'hFF00, w1: 16'h0180};
        rx_tbl[2] = '{nb: 2, b: 32'h1234_0000, exp_count: 1, w0: 16'h1234, w1: 16'h0000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_rx_count", 32'(rx_count), 32'd0);
        check("rst_flags", {30'd0, rx_overflow, rx_timeout}, 32'd0);
        check("rst_rx_clr", 32'(rx_ready_clr), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven TX vectors
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) tx_words[i] = tx_tbl[v].w[i];
            run_tx(int'(tx_tbl[v].n), int'(tx_tbl[v].l), 1'b1);
            exp_q.delete();
            for (int i = 0; i < 2 * int'(tx_tbl[v].n); i++) exp_q.push_back(tx_tbl[v].exp[i]);
            compare_got($sformatf("tx_vec%0d", v));
        end

        // word_count 0: done two cycles after start, no write pulse
        w0 = wr_pulses;
        @(negedge clk);
        start = 1'b1; word_count = 5'd0;
        @(negedge clk);
        start = 1'b0;
        check("wc0_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("wc0_done", 32'(done), 32'd1);
        @(negedge clk);
        check("wc0_done_drop", 32'(done), 32'd0);
        check("wc0_no_wr", 32'(wr_pulses - w0), 32'd0);

        // Transmitter held busy; second start and a load while busy are ignored
        tx_words[0] = 16'h5566; tx_words[1] = 16'h7788;
        load_word(0, tx_words[0]); load_word(1, tx_words[1]);
        lat = 4;
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        got_q.delete();
        d0 = done_cnt; w0 = wr_pulses;
        pulse_start(2);
        repeat (50) @(negedge clk);
        check("hold_no_wr", 32'(wr_pulses - w0), 32'd0);
        check("hold_busy_out", 32'(busy), 32'd1);
        load_word(1, 16'hDEAD);
        pulse_start(1);
        hold_busy = 1'b0;
        wait_done(d0, 5000);
        check("hold_wr_count", 32'(wr_pulses - w0), 32'd4);
        build_exp(2);
        compare_got("hold_bytes");

        // Reset in the middle of a transfer, then restart from the kept buffer
        tx_words[0] = 16'hA1B2; tx_words[1] = 16'hC3D4;
        load_word(0, tx_words[0]); load_word(1, tx_words[1]);
        lat = 10;
        w0 = wr_pulses;
        pulse_start(2);
        k = 0;
        while (wr_pulses < w0 + 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("midrst_progress", 32'(wr_pulses - w0 >= 2), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_wr_en", 32'(tx_wr_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        busy_cnt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        run_tx(2, 4, 1'b0);
        build_exp(2);
        compare_got("midrst_restart");

        // Randomized TX against the byte model
        for (int it = 0; it < 5; it++) begin
            nw = int'($urandom_range(1, 6));
            for (int i = 0; i < nw; i++) tx_words[i] = 16'($urandom);
            run_tx(nw, int'($urandom_range(1, 5)), 1'b1);
            build_exp(nw);
            compare_got($sformatf("tx_rand%0d", it));
        end

        // LSB-first instance
        @(negedge clk);
        l_load_we = 1'b1; l_load_addr = 4'd0; l_load_data = 16'h1234;
        @(negedge clk);
        l_load_addr = 4'd1; l_load_data = 16'hBEEF;
        @(negedge clk);
        l_load_we = 1'b0;
        l_got.delete();
        d0 = l_done_cnt;
        l_start = 1'b1; l_word_count = 5'd2;
        @(negedge clk);
        l_start = 1'b0;
        k = 0;
        while (l_done_cnt <= d0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("lsb_done", 32'(l_done_cnt - d0), 32'd1);
        check("lsb_size", 32'(l_got.size()), 32'd4);
        if (l_got.size() == 4) begin
            check("lsb_b0", 32'(l_got[0]), 32'h34);
            check("lsb_b1", 32'(l_got[1]), 32'h12);
            check("lsb_b2", 32'(l_got[2]), 32'hEF);
            check("lsb_b3", 32'(l_got[3]), 32'hBE);
        end

        // Table-driven RX vectors
        for (int v = 0; v < 3; v++) begin
            clear_rx();
            k = clr_cnt;
            for (int i = 0; i < int'(rx_tbl[v].nb); i++) send_rx(rx_tbl[v].b[i]);
            repeat (2) @(negedge clk);
            check($sformatf("rx_vec%0d_clr", v), 32'(clr_cnt - k), rx_tbl[v].nb);
            check($sformatf("rx_vec%0d_count", v), 32'(rx_count), rx_tbl[v].exp_count);
            read_rx($sformatf("rx_vec%0d_w0", v), 0, rx_tbl[v].w0);
            if (rx_tbl[v].exp_count > 1) read_rx($sformatf("rx_vec%0d_w1", v), 1, rx_tbl[v].w1);
        end

        // Partial word times out; next two bytes form a clean word
        clear_rx();
        send_rx(8'h77);
        repeat (10) @(negedge clk);
        check("to_early", 32'(rx_timeout), 32'd0);
        repeat (12) @(negedge clk);
        check("to_set", 32'(rx_timeout), 32'd1);
        check("to_count", 32'(rx_count), 32'd0);
        send_rx(8'h9C); send_rx(8'h3E);
        check("to_clean_count", 32'(rx_count), 32'd1);
        read_rx("to_clean_word", 0, 16'h9C3E);

        // Word completing in the same cycle as start is dropped
        clear_rx();
        send_rx(8'h11);
        @(negedge clk);
        rx_byte = 8'h22; rx_ready = 1'b1; start = 1'b1; word_count = 5'd0;
        @(negedge clk);
        start = 1'b0;
        check("collide_clr", 32'(rx_ready_clr), 32'd1);
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("collide_count", 32'(rx_count), 32'd0);
        send_rx(8'h33); send_rx(8'h44);
        check("collide_next", 32'(rx_count), 32'd1);
        read_rx("collide_word", 0, 16'h3344);

        // Overflow: DEPTH+1 words
        clear_rx();
        for (int i = 0; i <= int'(DEP); i++) begin
            send_rx(8'(i)); send_rx(8'(8'hF0 ^ i));
        end
        check("ovf_count", 32'(rx_count), 32'(DEP));
        check("ovf_flag", 32'(rx_overflow), 32'd1);
        read_rx("ovf_last_kept", int'(DEP) - 1, {8'(DEP - 1), 8'(8'hF0 ^ (DEP - 1))});

        // Randomized RX against the word model
        for (int it = 0; it < 3; it++) begin
            clear_rx();
            exp_words.delete();
            nw = int'($urandom_range(0, 18));
            for (int i = 0; i < nw; i++) begin
                b0 = 8'($urandom); b1 = 8'($urandom);
                send_rx(b0); send_rx(b1);
                exp_words.push_back(16'((32'(b0) << 8) | 32'(b1)));
            end
            stored = (nw > int'(DEP)) ? int'(DEP) : nw;
            check($sformatf("rxr%0d_count", it), 32'(rx_count), 32'(stored));
            check($sformatf("rxr%0d_ovf", it), 32'(rx_overflow), 32'(nw > int'(DEP)));
            check($sformatf("rxr%0d_to", it), 32'(rx_timeout), 32'd0);
            for (int a = 0; a < stored; a++) read_rx($sformatf("rxr%0d_w%0d", it, a), a, exp_words[a]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
